// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler
//   Time-shares one 3-bit serial sequence checker among NCH requesting
//   channels. Slots are 3 clocks long and run continuously so the checker
//   (which has no enable) stays frame-aligned. Idle slots carry a filler
//   frame of 3'b000.
//
//   A round-robin arbiter picks a channel in the last cycle (phase 2) of
//   each slot. The granted code word is shifted out MSB-first in the next
//   slot. The checker's error output is sampled on the last bit, and a
//   tagged one-cycle response follows. Saturating per-channel error
//   counters track the sampled errors.
//
// Ports
//   Clock      system clock, rising edge
//   Reset      asynchronous active-low reset, shared with the checker
//   req_valid  per-channel request
//   req_code   per-channel code word, channel i at [3i+2:3i]
//   req_ready  one-hot grant, high only in the phase-2 cycle of a grant
//   det_din    serial bit to the checker
//   det_err    checker error output
//   rsp_valid  one-cycle result strobe
//   rsp_ch     channel tag of the completed frame (held until next result)
//   rsp_err    sampled checker error of that frame (held until next result)
//   clr_cnt    synchronous clear of all error counters
//   err_cnt    per-channel error counters, channel i at [CNT_W*i +: CNT_W]
//   busy       current slot carries a real (non-filler) frame
module seq_det_scheduler #(
    parameter int  NCH   = 4,
    parameter int  CNT_W = 8,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NCH-1:0]       req_valid,
    input  logic [3*NCH-1:0]     req_code,
    output logic [NCH-1:0]       req_ready,
    output logic                 det_din,
    input  logic                 det_err,
    output logic                 rsp_valid,
    output logic [CH_W-1:0]      rsp_ch,
    output logic                 rsp_err,
    input  logic                 clr_cnt,
    output logic [NCH*CNT_W-1:0] err_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);

    phase_t          phase;
    logic [2:0]      code;
    logic            slot_active;
    logic [CH_W-1:0] tag;
    logic [CH_W-1:0] rr_ptr;
    logic [CNT_W-1:0] cnt [NCH];

    logic [2:0]      codes [NCH];
    logic            grant_found;
    logic [CH_W-1:0] grant;
    logic [CH_W:0]   cand;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign codes[i]                    = req_code[3*i +: 3];
        assign err_cnt[CNT_W*i +: CNT_W]   = cnt[i];
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (cand >= NCH_V) begin
                cand = cand - NCH_V;
            end
            if (!grant_found && req_valid[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant       = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (phase == PH2 && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Serial output is a pure register mux, MSB first.
    always_comb begin
        case (phase)
            PH0:     det_din = code[2];
            PH1:     det_din = code[1];
            default: det_din = code[0];
        endcase
    end

    assign busy = slot_active;

    // Slot sequencer: phase counter, frame load, response generation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase       <= PH0;
            code        <= 3'b000;
            slot_active <= 1'b0;
            tag         <= '0;
            rr_ptr      <= CH_W'(NCH-1);
            rsp_valid   <= 1'b0;
            rsp_ch      <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (phase)
                PH0: phase <= PH1;
                PH1: phase <= PH2;
                default: begin
                    phase <= PH0;
                    // Last bit of the current frame is on det_din now.
                    if (slot_active) begin
                        rsp_valid <= 1'b1;
                        rsp_ch    <= tag;
                        rsp_err   <= det_err;
                    end
                    if (grant_found) begin
                        code        <= codes[grant];
                        slot_active <= 1'b1;
                        tag         <= grant;
                        rr_ptr      <= grant;
                    end else begin
                        code        <= 3'b000;
                        slot_active <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Error counters update on the same edge that launches the response,
    // so the new count is visible together with rsp_valid. Clear wins.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr_cnt) begin
                    cnt[i] <= '0;
                end else if (phase == PH2 && slot_active && det_err &&
                             tag == CH_W'(i)) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
`timescale 1ns/1ps
// Bench for seq_det_scheduler (NCH=4, CNT_W=2). Contains a small serial
// checker model driving det_err, a cycle-count based reference model with
// a per-cycle compare, and directed scenarios with literal expectations.
module tb_seq_det_scheduler;
    localparam int NCH   = 4;
    localparam int CNT_W = 2;
    localparam int CH_W  = 2;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [NCH-1:0]       req_valid;
    logic [3*NCH-1:0]     req_code;
    logic [NCH-1:0]       req_ready;
    logic                 det_din;
    logic                 det_err;
    logic                 rsp_valid;
    logic [CH_W-1:0]      rsp_ch;
    logic                 rsp_err;
    logic                 clr_cnt;
    logic [NCH*CNT_W-1:0] err_cnt;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    seq_det_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
        .det_din(det_din), .det_err(det_err),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_err(rsp_err),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Serial checker: flags an error on the third bit of a nonzero frame
    // with even parity (e.g. 110, 101, 011). force_err overrides.
    int         chk_ph;
    logic [1:0] chk_bits;
    logic       force_err;
    logic [2:0] chk_word;
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            chk_ph   <= 0;
            chk_bits <= 2'b00;
        end else begin
            chk_bits <= {chk_bits[0], det_din};
            chk_ph   <= (chk_ph == 2) ? 0 : chk_ph + 1;
        end
    end
    assign chk_word = {chk_bits, det_din};
    assign det_err  = force_err | ((chk_ph == 2) && (chk_word != 3'b000) && (^chk_word == 1'b0));

    // Reference model: slot position derived from cycles since reset.
    int         m_cyc, m_rr, m_ch, m_rch;
    logic       m_act, m_rv, m_rerr;
    logic [2:0] m_code;
    int         m_cnt [NCH];

    always @(negedge Clock) begin
        int ph, g, idx;
        logic found;
        logic [NCH-1:0] exp_ready;
        logic [NCH*CNT_W-1:0] exp_cnt;
        if (!Reset) begin
            m_cyc = 0; m_rr = NCH-1; m_act = 1'b0; m_ch = 0; m_code = 3'b000;
            m_rv = 1'b0; m_rch = 0; m_rerr = 1'b0;
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_det_din", det_din, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_ch", rsp_ch, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_err_cnt", err_cnt, 0);
        end else begin
            ph = m_cyc % 3;
            found = 1'b0; g = 0;
            if (ph == 2) begin
                for (int k = 1; k <= NCH; k++) begin
                    idx = (m_rr + k) % NCH;
                    if (!found && req_valid[idx]) begin found = 1'b1; g = idx; end
                end
            end
            exp_ready = '0;
            if (found) exp_ready[g] = 1'b1;
            exp_cnt = '0;
            for (int i = 0; i < NCH; i++) exp_cnt[CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
            chk("m_req_ready", req_ready, exp_ready);
            chk("m_det_din", det_din, m_code[2-ph]);
            chk("m_busy", busy, m_act);
            chk("m_rsp_valid", rsp_valid, m_rv);
            chk("m_rsp_ch", rsp_ch, m_rch);
            chk("m_rsp_err", rsp_err, m_rerr);
            chk("m_err_cnt", err_cnt, exp_cnt);
            // advance to next cycle
            m_rv = 1'b0;
            if (ph == 2) begin
                if (m_act) begin
                    m_rv = 1'b1; m_rch = m_ch; m_rerr = det_err;
                    if (det_err && m_cnt[m_ch] < (1 << CNT_W) - 1) m_cnt[m_ch] = m_cnt[m_ch] + 1;
                end
                if (found) begin
                    m_act = 1'b1; m_ch = g; m_code = req_code[3*g +: 3]; m_rr = g;
                end else begin
                    m_act = 1'b0; m_code = 3'b000;
                end
            end
            if (clr_cnt) for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_cyc = m_cyc + 1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [2:0] bits;
        logic [1:0] got4 [5];
        logic [1:0] exp4 [5];
        logic [NCH-1:0] gr [5];
        logic [NCH-1:0] exp_gr [5];
        int rc [4];
        int n, ng, nr;
        logic seen;
        exp4   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_gr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        Reset = 1'b0; req_valid = '0; req_code = '0; clr_cnt = 1'b0; force_err = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;

        // Single request on ch1 raised in phase 0; grant only in phase 2.
        req_code[5:3] = 3'b110; req_valid[1] = 1'b1;
        #1;
        chk("t5_ready_ph0", req_ready, 4'b0000);
        chk("t5_din_ph0", det_din, 0);
        tick(); #1;
        chk("t5_ready_ph1", req_ready, 4'b0000);
        chk("t5_din_ph1", det_din, 0);
        tick(); #1;
        chk("t5_ready_ph2", req_ready, 4'b0010);
        chk("t5_din_ph2", det_din, 0);
        tick(); req_valid = '0; bits[2] = det_din;
        tick(); bits[1] = det_din;
        tick(); bits[0] = det_din;
        chk("t1_bits", bits, 3'b110);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_ch", rsp_ch, 1);
        chk("t1_rsp_err", rsp_err, 1);
        chk("t1_err_cnt1", err_cnt[3:2], 1);

        // Filler slots with det_err forced high produce nothing.
        force_err = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t3_rsp_valid", rsp_valid, 0);
            chk("t3_busy", busy, 0);
            chk("t3_det_din", det_din, 0);
            chk("t3_err_cnt", err_cnt, 8'h04);
        end
        force_err = 1'b0;

        // Saturation on ch2 with CNT_W=2, then clear coincident with an error.
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        chk("t4_cleared", err_cnt, 0);
        req_code[8:6] = 3'b110; req_valid[2] = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (rsp_valid) begin got4[n] = err_cnt[5:4]; n++; end
        end
        chk("t4_resp_count", n, 5);
        for (int i = 0; i < n; i++) chk("t4_sat_seq", got4[i], exp4[i]);
        tick(); tick();
        clr_cnt = 1'b1; req_valid = '0;
        tick(); clr_cnt = 1'b0;
        chk("t4_clr_rsp_valid", rsp_valid, 1);
        chk("t4_clr_rsp_ch", rsp_ch, 2);
        chk("t4_clr_rsp_err", rsp_err, 1);
        chk("t4_clr_wins", err_cnt[5:4], 0);

        // Reset during phase 1 of an active frame on ch3.
        req_code[11:9] = 3'b101; req_valid[3] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (req_ready[3]) seen = 1'b1;
            else tick();
        end
        chk("t6_grant_seen", seen, 1);
        tick(); req_valid = '0;
        tick();
        Reset = 1'b0; #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        tick(); tick();
        Reset = 1'b1;
        chk("t6_rel_rsp_valid", rsp_valid, 0);

        // All channels requesting: round-robin from ch0.
        req_code = {3'b011, 3'b101, 3'b110, 3'b001};
        req_valid = 4'b1111;
        ng = 0; nr = 0;
        for (int c = 0; c < 40 && (ng < 5 || nr < 4); c++) begin
            #1;
            if (req_ready != '0 && ng < 5) begin gr[ng] = req_ready; ng++; end
            if (rsp_valid && nr < 4) begin rc[nr] = int'(rsp_ch); nr++; end
            tick();
        end
        req_valid = '0;
        chk("t2_grant_count", ng, 5);
        chk("t2_rsp_count", nr, 4);
        for (int i = 0; i < ng; i++) chk("t2_grant_order", gr[i], exp_gr[i]);
        for (int i = 0; i < nr; i++) chk("t2_rsp_order", rc[i], i);

        repeat (8) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Shares one 3-bit serial sequence checker among NCH requesting channels.
- Each channel offers a 3-bit code word. The block arbitrates round-robin, serialises the granted word MSB-first onto the checker's serial input, and samples the checker's error output on the last bit.
- Returns a tagged per-frame result and keeps saturating per-channel error counts.
- Keeps the checker's frame alignment. The checker advances on every clock and has no enable, so 3-cycle slots run continuously and idle slots carry a filler frame.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CNT_W, 8, width of each per-channel error counter.
- CH_W, clog2(NCH) (derived, not overridable), width of the channel tag.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset. It is shared with the checker so that both leave reset aligned.
- req_valid  input  NCH  per-channel request.
- req_code  input  3*NCH  per-channel code word; channel i occupies bits [3i+2:3i].
- req_ready  output  NCH  one-hot grant/accept.
- det_din  output  1  serial bit to the checker's Din.
- det_err  input  1  checker's ERR output.
- rsp_valid  output  1  one-cycle result strobe.
- rsp_ch  output  CH_W  channel of the completed frame.
- rsp_err  output  1  sampled det_err for that frame.
- clr_cnt  input  1  synchronous clear of all error counters.
- err_cnt  output  NCH*CNT_W  per-channel error counts; channel i at [CNT_W*i +: CNT_W].
- busy  output  1  current slot carries a real (non-filler) frame.

Behaviour:

Reset values:
- phase=0; slot_active=0; shift code=3'b000.
- rr_ptr=NCH-1, so channel 0 has first priority.
- req_ready=0; rsp_valid=0; rsp_ch=0; rsp_err=0; busy=0; all err_cnt=0.

Slot timing:
- phase is a free-running 0,1,2,0... counter that advances every clock from reset release. The checker sits in its start state whenever phase==0.
- det_din = code[2-phase]: MSB in phase 0, LSB in phase 2. It is a mux of registers only.

Arbitration:
- Arbitration is evaluated only in a phase-2 cycle.
- Grant goes to the first i with req_valid[i]=1, searching from rr_ptr+1 upward with wrap.
- req_ready[grant]=1 (combinational) in that cycle only; req_ready=0 in phase 0 and 1.
- Handshake is req_valid&req_ready. On the phase-2→0 edge the block:
  - latches req_code[grant] into the shift code,
  - sets slot_active=1,
  - stores the tag,
  - sets rr_ptr=grant.
- Requesters hold valid and code stable until accepted; dropping valid before accept is legal and simply forfeits the grant.
- With no valid request in phase 2: the next slot is filler (code 3'b000, slot_active=0), rr_ptr is unchanged, and no response is produced.

Result:
- On the edge ending phase 2 of an active slot, det_err is sampled.
- In the following cycle (the next phase 0): rsp_valid=1, rsp_ch=tag, rsp_err=sample. rsp_valid lasts exactly one cycle.
- rsp_ch and rsp_err hold their values until the next response.
- Filler slots never produce rsp_valid, even if det_err=1.

Latency:
- Accept in cycle T (phase 2) → bits driven in T+1..T+3 → rsp_valid in T+4.
- Back-to-back frames: one result every 3 cycles. A response for one frame coincides with phase 0 of the next.

busy: equals slot_active (phases 0–2 of a real frame).

Counters:
- On the response edge, when the sample is 1, err_cnt[tag] increments and saturates at 2^CNT_W-1.
- clr_cnt=1 clears all counters at the next edge. Clear wins over a coincident increment.

Fairness: a continuously requesting channel waits at most NCH slots (3*NCH cycles).

Reset mid-operation:
- All state returns to reset values immediately.
- An in-flight frame is dropped with no response. Its requester's handshake already completed, so the frame is lost by design.
- phase restarts at 0 together with the checker.

Test Plan:
1. Single request: ch1 code 3'b110, checker model asserting det_err on the 3rd bit → req_ready[1] in a phase-2 cycle; det_din 1,1,0; 4 cycles after accept rsp_valid=1, rsp_ch=1, rsp_err=1; err_cnt[1]=1.
2. All 4 channels valid continuously → grants in order 0,1,2,3,0 on successive phase-2 cycles; rsp_valid every 3 cycles with rsp_ch 0,1,2,3.
3. Idle then det_err forced 1 during a filler slot → det_din=0 for 3 cycles; busy=0; no rsp_valid; counters unchanged.
4. CNT_W=2, ch2 sends 5 erroring frames → err_cnt[2] sequence 1,2,3,3,3. Then clr_cnt coincident with a 6th error → err_cnt[2]=0.
5. Request raised in phase 0 → req_ready stays 0 until phase 2; accept then; no bit of that code appears before the next phase 0.
6. Reset asserted during phase 1 of an active frame → no rsp_valid. After release: phase=0, rr_ptr=NCH-1, ch0 is granted first if all channels request.
